// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA timing interface.
//
// Measures incoming line/frame timing from HS/VS/BLANK. It locks once two
// consecutive frames measure identically and match the expected active size.
// While locked, it recovers the pixel X/Y position and issues frame-buffer
// write strobes with the linear address Y*P_H_ACT+X.
//
// Ports:
//   iCLK, iRST          pixel clock, synchronous active-high reset
//   iVGA_HS, iVGA_VS    active-low syncs
//   iVGA_BLANK          1 = active video
//   iVGA_R/G/B          8-bit colour components
//   oWrite              one-cycle write strobe per captured pixel
//   oAddress, oData     write address (Y*P_H_ACT+X) and {R,G,B}
//   oCurrent_X/Y        position of the pixel on oData
//   oFrame_Start        pulse at each VS falling edge while locked
//   oLocked             high while timing is locked
//   oError              pulse on loss of lock
//   oH_Total, oV_Total  last measured clocks/line and lines/frame
module vga_capture #(
    parameter int P_H_ACT   = 640,
    parameter int P_V_ACT   = 480,
    parameter int P_TIMEOUT = 1000000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iVGA_HS,
    input  logic        iVGA_VS,
    input  logic        iVGA_BLANK,
    input  logic [7:0]  iVGA_R,
    input  logic [7:0]  iVGA_G,
    input  logic [7:0]  iVGA_B,
    output logic        oWrite,
    output logic [21:0] oAddress,
    output logic [23:0] oData,
    output logic [10:0] oCurrent_X,
    output logic [10:0] oCurrent_Y,
    output logic        oFrame_Start,
    output logic        oLocked,
    output logic        oError,
    output logic [11:0] oH_Total,
    output logic [10:0] oV_Total
);

    typedef enum logic [1:0] {SEARCH, MEAS1, MEAS2, LOCKED} state_t;

    localparam logic [10:0] H_ACT_L   = 11'(P_H_ACT);
    localparam logic [10:0] V_ACT_L   = 11'(P_V_ACT);
    localparam logic [21:0] H_ACT_A   = 22'(P_H_ACT);
    localparam logic [31:0] WD_LIMIT  = 32'(P_TIMEOUT);
    localparam logic [31:0] WD_REACH  = 32'(P_TIMEOUT - 1);

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // Stage 1: registered inputs
    logic        hs_p1, vs_p1, vld_p1;
    logic [23:0] rgb_p1;
    // Stage 2: delayed copies used only for edge detection
    logic        hs_p2, vs_p2, vld_p2;

    always_ff @(posedge iCLK) begin
        rgb_p1 <= {iVGA_R, iVGA_G, iVGA_B};
        if (iRST) begin
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            vld_p1 <= 1'b0;
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            hs_p1  <= iVGA_HS;
            vs_p1  <= iVGA_VS;
            vld_p1 <= iVGA_BLANK;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            vld_p2 <= vld_p1;
        end
    end

    logic hs_fall, vs_fall, line_end;
    assign hs_fall  = hs_p2 & ~hs_p1;
    assign vs_fall  = vs_p2 & ~vs_p1;
    assign line_end = vld_p2 & ~vld_p1;

    // Timing counters
    logic [11:0] h_cnt, line_len;
    logic [10:0] x_cnt, x_max, y_cnt, line_cnt;
    logic [31:0] wd_cnt;

    logic [10:0] cur_x, cur_y, x_next, y_next, x_max_next;
    logic [11:0] line_len_next;
    logic [44:0] meas;

    always_comb begin
        // An edge in the current sample resets the position before this
        // sample is placed, so the first pixel of a line/frame lands at 0.
        cur_x         = hs_fall ? 11'd0 : x_cnt;
        cur_y         = vs_fall ? 11'd0 : y_cnt;
        x_next        = vld_p1   ? sat_inc11(cur_x) : cur_x;
        y_next        = line_end ? sat_inc11(cur_y) : cur_y;
        line_len_next = hs_fall ? h_cnt : line_len;
        x_max_next    = x_max;
        if (vs_fall)
            x_max_next = x_next;
        else if (x_next > x_max)
            x_max_next = x_next;
        // Frame measurement {H, HA, V, VA} as seen at a VS falling edge.
        meas = {line_len_next, x_max, line_cnt, y_cnt};
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            h_cnt    <= '0;
            line_len <= '0;
            x_cnt    <= '0;
            x_max    <= '0;
            y_cnt    <= '0;
            line_cnt <= '0;
            wd_cnt   <= '0;
        end else begin
            h_cnt    <= hs_fall ? 12'd1 : sat_inc12(h_cnt);
            line_len <= line_len_next;
            x_cnt    <= x_next;
            x_max    <= x_max_next;
            y_cnt    <= y_next;
            // A coincident HS edge belongs to the frame that VS is closing
            // and is not counted into the new one.
            if (vs_fall)
                line_cnt <= '0;
            else if (hs_fall)
                line_cnt <= sat_inc11(line_cnt);
            if (vs_fall)
                wd_cnt <= '0;
            else if (wd_cnt != WD_LIMIT)
                wd_cnt <= wd_cnt + 32'd1;
        end
    end

    // Lock state machine
    state_t      state, state_next;
    logic [44:0] ref_q, ref_next;
    logic        fs_next, err_next, timeout;

    assign timeout = !vs_fall && (wd_cnt == WD_REACH);

    always_comb begin
        state_next = state;
        ref_next   = ref_q;
        fs_next    = 1'b0;
        err_next   = 1'b0;
        if (timeout && state != SEARCH) begin
            state_next = SEARCH;
            err_next   = (state == LOCKED);
        end else if (vs_fall) begin
            unique case (state)
                SEARCH: state_next = MEAS1;
                MEAS1: begin
                    ref_next   = meas;
                    state_next = MEAS2;
                end
                MEAS2: begin
                    // ref_q holds the previous frame; once it matches and the
                    // active size is right it becomes the lock reference.
                    if (meas == ref_q && x_max == H_ACT_L && y_cnt == V_ACT_L) begin
                        state_next = LOCKED;
                        fs_next    = 1'b1;
                    end else begin
                        ref_next   = meas;
                    end
                end
                LOCKED: begin
                    if (meas == ref_q) begin
                        fs_next    = 1'b1;
                    end else begin
                        err_next   = 1'b1;
                        state_next = MEAS1;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= SEARCH;
            ref_q <= '0;
        end else begin
            state <= state_next;
            ref_q <= ref_next;
        end
    end

    // Capture decision and address for the stage-1 sample
    logic        wr;
    logic [21:0] addr;
    assign wr   = (state == LOCKED) && vld_p1 && (cur_x < H_ACT_L) && (cur_y < V_ACT_L);
    assign addr = 22'(cur_y) * H_ACT_A + 22'(cur_x);

    // Stage 2: registered outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oWrite       <= 1'b0;
            oAddress     <= '0;
            oData        <= '0;
            oCurrent_X   <= '0;
            oCurrent_Y   <= '0;
            oFrame_Start <= 1'b0;
            oLocked      <= 1'b0;
            oError       <= 1'b0;
            oH_Total     <= '0;
            oV_Total     <= '0;
        end else begin
            oWrite       <= wr;
            oFrame_Start <= fs_next;
            oError       <= err_next;
            oLocked      <= (state_next == LOCKED);
            if (wr) begin
                oAddress   <= addr;
                oData      <= rgb_p1;
                oCurrent_X <= cur_x;
                oCurrent_Y <= cur_y;
            end
            if (vs_fall) begin
                oH_Total <= line_len_next;
                oV_Total <= line_cnt;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture using a reduced raster (16x6 active in 20x10 total)
// so that many frames fit in a short run. Expected writes are queued by the
// stimulus and consumed by an independent monitor on every oWrite.
module tb_vga_capture;

    localparam int HA = 16;
    localparam int VA = 6;
    localparam int TO = 5000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, hs, vs, blank;
    logic [7:0]  r, g, b;
    logic        oWrite, oFrame_Start, oLocked, oError;
    logic [21:0] oAddress;
    logic [23:0] oData;
    logic [10:0] oCurrent_X, oCurrent_Y, oV_Total;
    logic [11:0] oH_Total;

    vga_capture #(.P_H_ACT(HA), .P_V_ACT(VA), .P_TIMEOUT(TO)) dut (
        .iCLK(clk), .iRST(rst), .iVGA_HS(hs), .iVGA_VS(vs), .iVGA_BLANK(blank),
        .iVGA_R(r), .iVGA_G(g), .iVGA_B(b),
        .oWrite(oWrite), .oAddress(oAddress), .oData(oData),
        .oCurrent_X(oCurrent_X), .oCurrent_Y(oCurrent_Y),
        .oFrame_Start(oFrame_Start), .oLocked(oLocked), .oError(oError),
        .oH_Total(oH_Total), .oV_Total(oV_Total)
    );

    typedef struct {
        logic [21:0] addr;
        logic [23:0] data;
        logic [10:0] x;
        logic [10:0] y;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;
    int   wr_tot = 0, fs_tot = 0, err_tot = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (oFrame_Start) fs_tot++;
        if (oError) err_tot++;
        if (oWrite) begin
            wr_tot++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h x=%0d y=%0d, required no write",
                         oAddress, oData, oCurrent_X, oCurrent_Y);
            end else begin
                mon_e = sb.pop_front();
                if (oAddress !== mon_e.addr || oData !== mon_e.data || oCurrent_X !== mon_e.x ||
                    oCurrent_Y !== mon_e.y || cyc != mon_e.cyc) begin
                    n_bad++;
                    $display("FAIL write: got addr=%0d data=%h x=%0d y=%0d cyc=%0d, required addr=%0d data=%h x=%0d y=%0d cyc=%0d",
                             oAddress, oData, oCurrent_X, oCurrent_Y, cyc,
                             mon_e.addr, mon_e.data, mon_e.x, mon_e.y, mon_e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs = 1'b1; vs = 1'b1; blank = 1'b0; {r, g, b} = 24'h0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0; {r, g, b} = 24'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One frame: HS low for clocks 0-1 of every line, active pixels in the
    // last ha clocks of lines 2..va+1, VS low for two lines starting at
    // clock vs_clk of line 0. rst_t >= 0 pulses iRST at that frame clock.
    task automatic frame(input int ht, input int ha, input int vt, input int va,
                         input bit vs_en, input int vs_clk, input bit exp_wr, input int rst_t);
        int t, px, py;
        bit act;
        for (int l = 0; l < vt; l++) begin
            for (int c = 0; c < ht; c++) begin
                @(negedge clk);
                t   = l * ht + c;
                px  = c - (ht - ha);
                py  = l - 2;
                act = (l >= 2) && (l < 2 + va) && (c >= ht - ha);
                hs  = (c >= 2);
                vs  = !(vs_en && ((l == 0 && c >= vs_clk) || l == 1 || (l == 2 && c < vs_clk)));
                blank = act;
                {r, g, b} = act ? {8'(px), 8'(py), 8'hA5} : 24'h0;
                rst = (t == rst_t);
                if (act && exp_wr && px < HA && py < VA && !(rst_t >= 0 && t >= rst_t - 1))
                    sb.push_back('{addr: 22'(py * HA + px), data: {8'(px), 8'(py), 8'hA5},
                                   x: 11'(px), y: 11'(py), cyc: cyc + 2});
            end
        end
    endtask

    task automatic clean(input bit exp_wr);
        frame(20, 16, 10, 6, 1'b1, 5, exp_wr, -1);
    endtask

    task automatic coinc(input bit exp_wr);
        frame(20, 16, 10, 6, 1'b1, 0, exp_wr, -1);
    endtask

    int w0;

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0; {r, g, b} = 24'h0;
        do_reset();
        check("reset_ctrl", {oWrite, oFrame_Start, oLocked, oError, oH_Total, oV_Total,
                             oCurrent_X, oCurrent_Y}, 96'd0);
        check("reset_data", {oAddress, oData}, 96'd0);
        idle(5);

        // Acquisition: lock on the third VS edge
        clean(1'b0);
        clean(1'b0);
        check("not_locked_early", oLocked, 1'b0);
        w0 = wr_tot;
        clean(1'b1);
        check("locked", oLocked, 1'b1);
        check("lock_frame_start", fs_tot, 1);
        check("h_total", oH_Total, 20);
        check("v_total", oV_Total, 10);
        check("writes_lock_frame", wr_tot - w0, HA * VA);
        w0 = wr_tot;
        clean(1'b1);
        check("writes_full_frame", wr_tot - w0, HA * VA);
        check("frame_start_locked", fs_tot, 2);

        // One long-line frame: error at the edge that closes it, then relock
        frame(21, 16, 10, 6, 1'b1, 5, 1'b1, -1);
        check("no_error_yet", err_tot, 0);
        clean(1'b0);
        check("error_pulse", err_tot, 1);
        check("unlocked_on_error", oLocked, 1'b0);
        check("h_total_801", oH_Total, 21);
        check("frame_start_before_err", fs_tot, 3);
        clean(1'b0);
        check("not_relocked_yet", oLocked, 1'b0);
        clean(1'b1);
        check("relocked", oLocked, 1'b1);
        check("single_error", err_tot, 1);

        // Watchdog: VS held high while locked
        clean(1'b1);
        for (int i = 0; i < 20; i++) frame(20, 0, 10, 0, 1'b0, 0, 1'b0, -1);
        check("no_early_timeout", err_tot, 1);
        check("still_locked", oLocked, 1'b1);
        for (int i = 0; i < 10; i++) frame(20, 0, 10, 0, 1'b0, 0, 1'b0, -1);
        check("timeout_error", err_tot, 2);
        check("timeout_unlocked", oLocked, 1'b0);
        clean(1'b0);
        clean(1'b0);
        check("timeout_to_search", oLocked, 1'b0);
        clean(1'b1);
        check("relock_after_timeout", oLocked, 1'b1);

        // Coincident HS/VS edges: the coincident HS is not counted
        do_reset();
        coinc(1'b0);
        coinc(1'b0);
        coinc(1'b1);
        check("coinc_locked", oLocked, 1'b1);
        check("coinc_v_total", oV_Total, 9);
        check("coinc_h_total", oH_Total, 20);

        // Reset in the middle of an active line while locked
        frame(20, 16, 10, 6, 1'b1, 0, 1'b1, 70);
        check("midreset_ctrl", {oWrite, oFrame_Start, oLocked, oError, oH_Total, oV_Total,
                                oCurrent_X, oCurrent_Y}, 96'd0);
        check("midreset_data", {oAddress, oData}, 96'd0);
        check("no_error_on_reset", err_tot, 2);
        coinc(1'b0);
        coinc(1'b0);
        coinc(1'b1);
        check("relock_after_reset", oLocked, 1'b1);

        // Oversized active width: stable timing but never locks
        do_reset();
        w0 = wr_tot;
        for (int i = 0; i < 4; i++) frame(24, 20, 10, 6, 1'b1, 5, 1'b0, -1);
        check("wide_never_locks", oLocked, 1'b0);
        check("wide_no_writes", wr_tot - w0, 0);
        check("wide_h_total", oH_Total, 24);
        check("wide_v_total", oV_Total, 10);

        idle(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive side of the VGA timing interface; consumes HS/VS/BLANK plus 8-bit RGB in the pixel clock domain.
- Measures incoming line/frame timing and locks when two consecutive frames are identical and match the expected active size.
- Once locked, recovers pixel X/Y and issues frame-buffer write strobes with linear address Y*P_H_ACT+X.
- Sits between an external VGA source (or our timing generator in loopback) and the frame-buffer write port.

Parameters:
P_H_ACT, 640, expected active pixels per line
P_V_ACT, 480, expected active lines per frame
P_TIMEOUT, 1000000, pixel clocks without a VS falling edge before dropping to SEARCH

Ports:
iCLK  input  1  pixel clock
iRST  input  1  synchronous reset, active-high
iVGA_HS  input  1  horizontal sync, active-low
iVGA_VS  input  1  vertical sync, active-low
iVGA_BLANK  input  1  1 = active video, 0 = blanking
iVGA_R  input  8  red
iVGA_G  input  8  green
iVGA_B  input  8  blue
oWrite  output  1  frame-buffer write strobe, one cycle per captured pixel
oAddress  output  22  write address, Y*P_H_ACT+X
oData  output  24  {R,G,B} of captured pixel
oCurrent_X  output  11  X of pixel on oData
oCurrent_Y  output  11  Y of pixel on oData
oFrame_Start  output  1  one-cycle pulse at each VS falling edge while locked
oLocked  output  1  1 = timing locked, capture active
oError  output  1  one-cycle pulse on loss of lock
oH_Total  output  12  last measured clocks per line
oV_Total  output  11  last measured lines per frame

Behaviour:
- Input stage: all inputs registered once (stage 1). HS/VS falling-edge detect uses stage 1 and a stage-2 copy.
- Output stage: a pixel on the inputs at cycle n appears on oData/oAddress/oWrite at cycle n+2. All outputs are registered.
- Reset: all outputs 0, state SEARCH, all counters 0.
- h_cnt: clears to 1 on an HS falling edge, else increments, saturating at 4095. On each HS falling edge, the prior h_cnt is latched as the line length.
- x: clears on an HS falling edge; increments after each active sample.
- y: clears on a VS falling edge; increments on the first blank sample after an active run, so it counts completed active lines.
- line_cnt: counts HS falling edges since the last VS falling edge.
- Simultaneous HS and VS falling edges: VS wins; line_cnt becomes 0 and the HS edge is not counted.
- Per-frame measurement, latched at each VS falling edge:
  - H = line length latched at the most recent HS edge.
  - HA = maximum x reached during the frame.
  - V = line_cnt.
  - VA = y.
- oH_Total and oV_Total update at every VS edge, in every state.
- State machine (transitions only on VS falling edges, except timeout):
  - SEARCH -> MEAS1.
  - MEAS1: store frame A = {H,HA,V,VA} -> MEAS2.
  - MEAS2: if the new frame equals A and HA==P_H_ACT and VA==P_V_ACT -> LOCKED, storing the reference; otherwise A := new frame and stay in MEAS2.
  - LOCKED, frame equals reference: stay; pulse oFrame_Start.
  - LOCKED, frame differs: pulse oError, oLocked=0 -> MEAS1. This edge starts the new measurement.
- The entry edge into LOCKED also pulses oFrame_Start.
- Timeout: a watchdog clears on every VS edge and increments otherwise. Reaching P_TIMEOUT in any state other than SEARCH -> SEARCH; pulse oError if the state was LOCKED.
- oLocked = 1 exactly while in LOCKED, registered (it rises the cycle after the locking edge is processed).
- Capture: oWrite=1 only in LOCKED, on an active sample, with x<P_H_ACT and y<P_V_ACT. Out-of-range pixels are dropped silently.
- Writes already issued in a frame later judged mismatched are not retracted.
- oAddress: y*P_H_ACT+x, computed in 22 bits (max 307199 at default parameters). oData, oCurrent_X and oCurrent_Y hold their last values while oWrite=0.
- Reset mid-frame: immediate return to SEARCH next cycle; no writes until relocked.

Test Plan:
- Ideal 640x480 source (H=800, V=525, HS 96 low, VS 2 low), 3 frames -> oLocked=1 after the 3rd VS falling edge; oH_Total=800, oV_Total=525; oFrame_Start pulse on that edge.
- Locked; pixel RGB = {x[7:0], y[7:0], 8'hA5} -> exactly 307200 writes per frame; pixel (639,479) yields oAddress=307199, oData={8'h7F,8'hDF,8'hA5}, 2 cycles after input.
- Locked, then one frame with H=801 -> oError pulse at that frame's end VS edge, oLocked=0; relock after two further clean frames.
- Source with 800 active pixels per line, stable timing -> never locks, oWrite stays 0, oH_Total reported correctly.
- Locked, VS held high for P_TIMEOUT (set to 5000) clocks -> oError pulse, oLocked=0, state SEARCH; next VS edge begins measurement.
- HS and VS falling on the same cycle, plus iRST asserted mid-line while locked -> line count unaffected by the coincident HS; after reset all outputs 0 and no writes until relock.
